// File: rtl/reaction_ctrl.sv
// Reaction-time monitor controller: button sync/edge detect, LFSR delay source,
// round FSM and result capture. Define REACTION_CTRL_BEST_TIME_EN to build the best-time tracker.
module reaction_ctrl #(
   parameter int CNT_W  = 16,
   parameter int RAND_W = 13
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              btn,
   input  logic              start_count,
   input  logic [CNT_W-1:0]  count,
   output logic [1:0]        cen,
   output logic [RAND_W-1:0] random,
   output logic              early,
   output logic [CNT_W-1:0]  result,
   output logic              result_valid,
   output logic [CNT_W-1:0]  best
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WAIT    = 3'd1,
      MEASURE = 3'd2,
      HOLD    = 3'd3,
      FOUL    = 3'd4
   } state_t;

   state_t            state, next_state;
   logic              sync1, sync2, btn_prev;
   logic              press;
   logic [RAND_W-1:0] lfsr;
   logic              lfsr_fb;
   logic              hold_seen;
   logic              capture;
   logic              arm;

   // Two-flop synchronizer plus rising-edge detector; no further debounce.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1    <= 1'b0;
         sync2    <= 1'b0;
         btn_prev <= 1'b0;
      end else begin
         sync1    <= btn;
         sync2    <= sync1;
         btn_prev <= sync2;
      end
   end

   assign press = sync2 & ~btn_prev;

   // Fibonacci taps for x^13+x^12+x^11+x^8+1; free-running in every state.
   assign lfsr_fb = lfsr[RAND_W-1] ^ lfsr[RAND_W-2] ^ lfsr[RAND_W-3] ^ lfsr[RAND_W-6];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr <= {{(RAND_W-1){1'b0}}, 1'b1};
      end else begin
         lfsr <= {lfsr[RAND_W-2:0], lfsr_fb};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      arm        = 1'b0;
      case (state)
         IDLE: begin
            if (press) begin
               next_state = WAIT;
               arm        = 1'b1;
            end
         end
         WAIT: begin
            if (press) begin
               next_state = FOUL;
            end else if (start_count) begin
               next_state = MEASURE;
            end
         end
         MEASURE: begin
            if (press || (count == {CNT_W{1'b1}})) begin
               next_state = HOLD;
            end
         end
         HOLD: begin
            if (press) begin
               next_state = IDLE;
            end
         end
         FOUL: begin
            if (press) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs decode the state register only, so no input reaches them combinationally.
   always_comb begin
      cen   = 2'b00;
      early = 1'b0;
      case (state)
         WAIT:    cen = 2'b01;
         MEASURE: cen = 2'b10;
         HOLD:    cen = 2'b11;
         FOUL:    early = 1'b1;
         default: cen = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         random <= '0;
      end else if (arm) begin
         random <= lfsr;
      end
   end

   // Capture happens once, on the first cycle spent in HOLD.
   assign capture = (state == HOLD) && !hold_seen;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_seen    <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         hold_seen    <= (state == HOLD);
         result_valid <= capture;
         if (capture) begin
            result <= count;
         end
      end
   end

`ifdef REACTION_CTRL_BEST_TIME_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         best <= {CNT_W{1'b1}};
      end else if (capture && (count < best)) begin
         best <= count;
      end
   end
`else
   assign best = {CNT_W{1'b1}};
`endif

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed bench for reaction_ctrl: vector table for full rounds, fouls and timeout,
// plus hand sequences for LFSR arming and asynchronous reset mid-measure.
module tb_reaction_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        btn;
   logic        start_count;
   logic [15:0] count;
   logic [1:0]  cen;
   logic [12:0] random;
   logic        early;
   logic [15:0] result;
   logic        result_valid;
   logic [15:0] best;

   int applied = 0;
   int miscompares = 0;

`ifdef REACTION_CTRL_BEST_TIME_EN
   localparam logic [15:0] B300 = 16'd300;
`else
   localparam logic [15:0] B300 = 16'hFFFF;
`endif

   reaction_ctrl #(.CNT_W(16), .RAND_W(13)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .btn          (btn),
      .start_count  (start_count),
      .count        (count),
      .cen          (cen),
      .random       (random),
      .early        (early),
      .result       (result),
      .result_valid (result_valid),
      .best         (best)
   );

   always #5 clk = ~clk;

   // Reference LFSR written as a masked parity of the tap set.
   logic [12:0] m;
   logic [12:0] snap;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) m <= 13'h0001;
      else        m <= {m[11:0], ^(m & 13'h1C80)};
   end

   typedef struct {
      logic        b;
      logic        s;
      logic [15:0] c;
      logic [1:0]  cen;
      logic        e;
      logic [15:0] r;
      logic        rv;
      logic [15:0] bs;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(logic b, logic s, logic [15:0] c, logic [1:0] ce,
                               logic e, logic [15:0] r, logic rv, logic [15:0] bs);
      vec_t v;
      v.b = b; v.s = s; v.c = c; v.cen = ce; v.e = e; v.r = r; v.rv = rv; v.bs = bs;
      vecs.push_back(v);
   endfunction

   function automatic void add_round(logic [15:0] c, logic [15:0] r0,
                                     logic [15:0] b0, logic [15:0] b1);
      add(1, 0, 0, 0, 0, r0, 0, b0);
      add(1, 0, 0, 0, 0, r0, 0, b0);
      add(0, 0, 0, 1, 0, r0, 0, b0);
      add(0, 0, 0, 1, 0, r0, 0, b0);
      add(0, 0, 0, 1, 0, r0, 0, b0);
      add(0, 1, 0, 2, 0, r0, 0, b0);
      add(0, 1, c, 2, 0, r0, 0, b0);
      add(1, 0, c, 2, 0, r0, 0, b0);
      add(1, 0, c, 2, 0, r0, 0, b0);
      add(0, 0, c, 3, 0, r0, 0, b0);
      add(0, 0, c, 3, 0, c, 1, b1);
      add(0, 0, c, 3, 0, c, 0, b1);
      add(1, 0, c, 3, 0, c, 0, b1);
      add(1, 0, c, 3, 0, c, 0, b1);
      add(0, 0, c, 0, 0, c, 0, b1);
      add(0, 0, c, 0, 0, c, 0, b1);
      add(0, 0, c, 0, 0, c, 0, b1);
   endfunction

   function automatic void add_foul(logic simul, logic [15:0] r, logic [15:0] bs);
      add(1, 0, 0, 0, 0, r, 0, bs);
      add(1, 0, 0, 0, 0, r, 0, bs);
      add(0, 0, 0, 1, 0, r, 0, bs);
      add(0, 0, 0, 1, 0, r, 0, bs);
      add(1, 0, 0, 1, 0, r, 0, bs);
      add(1, 0, 0, 1, 0, r, 0, bs);
      add(0, simul, 0, 0, 1, r, 0, bs);
      add(0, 0, 0, 0, 1, r, 0, bs);
      add(1, 0, 0, 0, 1, r, 0, bs);
      add(1, 0, 0, 0, 1, r, 0, bs);
      add(0, 0, 0, 0, 0, r, 0, bs);
      add(0, 0, 0, 0, 0, r, 0, bs);
      add(0, 0, 0, 0, 0, r, 0, bs);
   endfunction

   function automatic void add_timeout(logic [15:0] r0, logic [15:0] bs);
      add(1, 0, 0, 0, 0, r0, 0, bs);
      add(1, 0, 0, 0, 0, r0, 0, bs);
      add(0, 0, 0, 1, 0, r0, 0, bs);
      add(0, 0, 0, 1, 0, r0, 0, bs);
      add(0, 1, 0, 2, 0, r0, 0, bs);
      add(0, 0, 16'hFFFF, 3, 0, r0, 0, bs);
      add(0, 0, 16'hFFFF, 3, 0, 16'hFFFF, 1, bs);
      add(0, 0, 16'hFFFF, 3, 0, 16'hFFFF, 0, bs);
      add(1, 0, 16'hFFFF, 3, 0, 16'hFFFF, 0, bs);
      add(1, 0, 16'hFFFF, 3, 0, 16'hFFFF, 0, bs);
      add(0, 0, 0, 0, 0, 16'hFFFF, 0, bs);
      add(0, 0, 0, 0, 0, 16'hFFFF, 0, bs);
      add(0, 0, 0, 0, 0, 16'hFFFF, 0, bs);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      applied++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic b, input logic s);
      btn = b;
      start_count = s;
      snap = m;
      @(posedge clk);
      #1;
   endtask

   task automatic press_btn();
      step(1, 0);
      step(1, 0);
      step(0, 0);
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_cen"},    64'(cen), 64'd0);
      chk({tag, "_early"},  64'(early), 64'd0);
      chk({tag, "_result"}, 64'(result), 64'd0);
      chk({tag, "_rv"},     64'(result_valid), 64'd0);
      chk({tag, "_best"},   64'(best), 64'hFFFF);
      chk({tag, "_random"}, 64'(random), 64'd0);
   endtask

   initial begin
      logic [1:0] prev_cen;
      logic       prev_early;

      rst_n = 1'b1; btn = 1'b0; start_count = 1'b0; count = 16'd0;
      #2 rst_n = 1'b0;
      #1 chk_reset_vals("por");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      add_round(16'd300, 16'd0, 16'hFFFF, B300);
      add_round(16'd450, 16'd300, B300, B300);
      add_foul(1'b0, 16'd450, B300);
      add_foul(1'b1, 16'd450, B300);
      add_timeout(16'd450, B300);

      prev_cen = 2'd0;
      prev_early = 1'b0;
      foreach (vecs[i]) begin
         count = vecs[i].c;
         step(vecs[i].b, vecs[i].s);
         chk($sformatf("vec%0d", i),
             64'({cen, early, result, result_valid, best}),
             64'({vecs[i].cen, vecs[i].e, vecs[i].r, vecs[i].rv, vecs[i].bs}));
         if (prev_cen == 2'd0 && !prev_early && vecs[i].cen == 2'd1) begin
            chk($sformatf("vec%0d_random", i), 64'(random), 64'(snap));
         end
         prev_cen = vecs[i].cen;
         prev_early = vecs[i].e;
      end

      // Repeated arming at varied phases of the LFSR.
      count = 16'd0;
      for (int k = 0; k < 40; k++) begin
         press_btn();
         chk($sformatf("arm%0d_cen", k), 64'(cen), 64'd1);
         chk($sformatf("arm%0d_random", k), 64'(random), 64'(snap));
         if (random == 13'd0) begin
            applied++;
            miscompares++;
            $display("FAIL arm%0d_nonzero: random %h, expected nonzero", k, random);
         end
         step(0, 0);
         step(0, 0);
         press_btn();
         step(0, 0);
         step(0, 0);
         press_btn();
         for (int g = 0; g < 1 + (k % 4); g++) step(0, 0);
      end
      chk("arm_end_cen", 64'(cen), 64'd0);

      // Asynchronous reset while measuring.
      press_btn();
      step(0, 0);
      step(0, 1);
      count = 16'd1234;
      step(0, 0);
      chk("pre_rst_cen", 64'(cen), 64'd2);
      chk("pre_rst_result", 64'(result), 64'hFFFF);
      #1 rst_n = 1'b0;
      #1 chk_reset_vals("midrst");
      @(negedge clk) rst_n = 1'b1;
      count = 16'd0;

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
